rv_iommu_pdtc_plru: RTL and testbench
=====================================

# rv_iommu_pdtc_plru

Parametrised, registered process-directory-table cache for the IOMMU translation pipeline. It sits between the device-context stage and the first-stage page walker. It caches ENS, SUM, PSCID and FSC (mode and PPN) per (device_id, process_id) tag. The block adds configurable depth, tree-PLRU replacement, valid/ready handshakes with registered responses, three invalidation scopes, duplicate-free fills and saturating hit/miss counters.

## Interface
- MAX_PPN, 34, FSC PPN width
- ENTRIES, 8, number of entries; power of 2, at least 2
- DID_W, 24, device_id width
- PID_W, 20, process_id width
- CNT_W, 16, hit/miss counter width
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- req_valid_i  input  1  lookup/fill request valid
- req_ready_o  output  1  request accepted when valid & ready
- req_fill_i  input  1  0 = lookup, 1 = fill
- req_device_id_i  input  DID_W  tag
- req_process_id_i  input  PID_W  tag
- fill_ens_i / fill_sum_i  input  1 each  fill data
- fill_pscid_i  input  20  fill data
- fill_fsc_mode_i  input  4  fill data
- fill_fsc_ppn_i  input  MAX_PPN  fill data
- rsp_valid_o  output  1  one-cycle response pulse
- rsp_hit_o  output  1  lookup hit; always 0 for fills
- rsp_ens_o, rsp_sum_o, rsp_pscid_o, rsp_fsc_mode_o, rsp_fsc_ppn_o  output  1/1/20/4/MAX_PPN  hit data; zero on miss and fill
- inval_valid_i  input  1  invalidation request
- inval_ready_o  output  1  always 1 outside reset
- inval_scope_i  input  2  0 = all, 1 = device, 2 = device+process, 3 = reserved, treated as 0
- inval_device_id_i / inval_process_id_i  input  DID_W / PID_W  match values
- inval_done_o  output  1  one-cycle pulse
- hit_cnt_o, miss_cnt_o  output  CNT_W each  saturating lookup counters

## Operation
- Storage per entry: valid bit, tags and data, all in flops. PLRU state is ENTRIES-1 tree bits.
- Arbitration:
  - Invalidation has priority over requests.
  - req_ready_o = !rst & !inval_valid_i.
  - No response backpressure.
- Lookup:
  - Hit when a valid entry matches both tags. Tag uniqueness is guaranteed by the fill rule, so at most one entry matches.
  - A hit sets the PLRU path to point away from the hit entry and increments hit_cnt.
  - A miss changes no entry or PLRU state and increments miss_cnt.
- Fill target selection, in order:
  1. The valid entry with matching tags: overwrite it, so no duplicates.
  2. Otherwise the lowest-index invalid entry.
  3. Otherwise the PLRU victim.
- Fill effects: the target's tags and data are written, valid is set, and PLRU marks the target MRU. Counters are unchanged.
- PLRU convention:
  - Node bit 0 means the victim is in the lower-index subtree.
  - Touching an entry sets each node on its path to point to the opposite subtree.
- Invalidation clears the valid bit of every entry matching the scope:
  - scope all: every entry.
  - scope device: device tag equal.
  - scope device+process: both tags equal.
  - PLRU is unchanged. Zero matches still completes.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset (async assert, sync release):
  - All valid bits, PLRU bits and counters go to 0.
  - rsp_valid_o, rsp_hit_o, all rsp data and inval_done_o go to 0.
  - req_ready_o and inval_ready_o are 0 while rst=1.
  - A request accepted before the cycle in which rst asserts produces no response.

## Timing
- Request accepted on edge N → rsp_valid_o=1 for exactly cycle N+1, with registered data from the pre-edge-N state.
- A fill accepted at edge N is visible to a lookup accepted at edge N+1. Back-to-back requests are sustained at 1/cycle.
- Invalidation accepted at edge N:
  - inval_done_o pulses in cycle N+1.
  - Cleared entries miss for lookups accepted at edge N+1 onward.
- inval_valid_i and req_valid_i high together: the invalidation is taken, req_ready_o=0, and the request holds its payload stable until accepted.
- A response already registered in cycle N+1 is delivered unchanged even if an invalidation for that tag completes in the same cycle.
- Counters update on the acceptance edge; the new value is visible in cycle N+1.

## Test plan
- Reset, fill (dev 0x000012, pid 0x00034, pscid 0x0ABCD, mode 8, ppn 0x123), then lookup the same tag → rsp_hit_o=1 with identical data one cycle after acceptance; hit_cnt_o=1.
- ENTRIES=8: fill 8 distinct tags, lookup tags 0,2,4,6, then fill a 9th tag. Required: the entry chosen by PLRU from the tree-bit convention is replaced, and the 9th tag then hits. A second fill of the 9th tag with new pscid overwrites in place: no other tag is lost and the lookup returns the new pscid.
- Fill (dev 5, pid 1), (dev 5, pid 2), (dev 6, pid 1), then invalidate scope device, dev 5. Required: inval_done_o pulses 1 cycle later; the two dev-5 tags miss and (6,1) hits. Then invalidate scope all → every lookup misses.
- Hold inval_valid_i and req_valid_i high together for 3 cycles. Required: req_ready_o=0 for those cycles, three inval_done_o pulses, and the lookup is accepted in the 4th cycle.
- CNT_W=2: 5 missing lookups → miss_cnt_o reads 1,2,3,3,3.
- Assert rst mid-stream with a fill accepted in the prior cycle. Required: all outputs 0 immediately, and after release the filled tag misses.

Source files
------------

// File: rtl/rv_iommu_pdtc_plru.sv
// Process-directory-table cache: flop-based storage, tree-PLRU replacement,
// registered single-cycle responses, scoped invalidation and saturating counters.
module rv_iommu_pdtc_plru #(
   parameter int MAX_PPN = 34,
   parameter int ENTRIES = 8,
   parameter int DID_W   = 24,
   parameter int PID_W   = 20,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic               req_fill_i,
   input  logic [DID_W-1:0]   req_device_id_i,
   input  logic [PID_W-1:0]   req_process_id_i,
   input  logic               fill_ens_i,
   input  logic               fill_sum_i,
   input  logic [19:0]        fill_pscid_i,
   input  logic [3:0]         fill_fsc_mode_i,
   input  logic [MAX_PPN-1:0] fill_fsc_ppn_i,
   output logic               rsp_valid_o,
   output logic               rsp_hit_o,
   output logic               rsp_ens_o,
   output logic               rsp_sum_o,
   output logic [19:0]        rsp_pscid_o,
   output logic [3:0]         rsp_fsc_mode_o,
   output logic [MAX_PPN-1:0] rsp_fsc_ppn_o,
   input  logic               inval_valid_i,
   output logic               inval_ready_o,
   input  logic [1:0]         inval_scope_i,
   input  logic [DID_W-1:0]   inval_device_id_i,
   input  logic [PID_W-1:0]   inval_process_id_i,
   output logic               inval_done_o,
   output logic [CNT_W-1:0]   hit_cnt_o,
   output logic [CNT_W-1:0]   miss_cnt_o
);
   localparam int IDX_W = $clog2(ENTRIES);

   typedef struct packed {
      logic               ens;
      logic               sum;
      logic [19:0]        pscid;
      logic [3:0]         fsc_mode;
      logic [MAX_PPN-1:0] fsc_ppn;
   } pdt_data_t;

   logic [ENTRIES-1:0] valid;
   logic [DID_W-1:0]   did_tag  [ENTRIES];
   logic [PID_W-1:0]   pid_tag  [ENTRIES];
   pdt_data_t          data_mem [ENTRIES];
   // Heap-ordered tree: node 1 is the root, children of node n are 2n and 2n+1.
   logic [ENTRIES-1:1] plru, plru_touched;

   logic               hit, has_free;
   logic [IDX_W-1:0]   hit_idx, free_idx, victim_idx, fill_idx, touch_idx;
   logic [ENTRIES-1:0] inval_match;
   logic               req_take, fill_take;
   pdt_data_t          fill_data, rsp_data;
   logic               rsp_valid, rsp_hit, inval_done;
   logic [CNT_W-1:0]   hit_cnt, miss_cnt;

   assign req_ready_o   = ~rst & ~inval_valid_i;
   assign inval_ready_o = ~rst;
   assign req_take      = req_valid_i & req_ready_o;
   assign fill_take     = req_take & req_fill_i;
   assign fill_data     = {fill_ens_i, fill_sum_i, fill_pscid_i, fill_fsc_mode_i, fill_fsc_ppn_i};

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid[i] && did_tag[i] == req_device_id_i && pid_tag[i] == req_process_id_i) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
      has_free = 1'b0;
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            has_free = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      // NOTE: node/path/b are scratch variables local to this block; blocking
      // assignment is correct here because each is written before it is read.
      logic [IDX_W-1:0] node;
      logic [IDX_W-1:0] path;
      logic             b;
      victim_idx = '0;
      node       = IDX_W'(1);
      for (int l = 0; l < IDX_W; l++) begin
         b          = plru[node];
         victim_idx = IDX_W'({victim_idx, b});
         node       = IDX_W'({node, b});
      end
      fill_idx  = hit ? hit_idx : (has_free ? free_idx : victim_idx);
      touch_idx = req_fill_i ? fill_idx : hit_idx;
      // Each node on the touched path is pointed at the sibling subtree.
      plru_touched = plru;
      node         = IDX_W'(1);
      path         = touch_idx;
      for (int l = 0; l < IDX_W; l++) begin
         b                  = path[IDX_W-1];
         plru_touched[node] = ~b;
         node               = IDX_W'({node, b});
         path               = path << 1;
      end
   end

   always_comb begin
      inval_match = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         unique case (inval_scope_i)
            2'd1:    inval_match[i] = did_tag[i] == inval_device_id_i;
            2'd2:    inval_match[i] = did_tag[i] == inval_device_id_i &&
                                      pid_tag[i] == inval_process_id_i;
            default: inval_match[i] = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid      <= '0;
         plru       <= '0;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
         rsp_valid  <= 1'b0;
         rsp_hit    <= 1'b0;
         rsp_data   <= '0;
         inval_done <= 1'b0;
      end else begin
         rsp_valid  <= 1'b0;
         rsp_hit    <= 1'b0;
         rsp_data   <= '0;
         inval_done <= inval_valid_i;
         if (inval_valid_i) begin
            valid <= valid & ~inval_match;
         end else if (req_valid_i) begin
            rsp_valid <= 1'b1;
            if (req_fill_i) begin
               valid[fill_idx] <= 1'b1;
               plru            <= plru_touched;
            end else if (hit) begin
               rsp_hit  <= 1'b1;
               rsp_data <= data_mem[hit_idx];
               plru     <= plru_touched;
               if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end else begin
               if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
         end
      end
   end

   // NOTE: tags and data are not reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (fill_take) begin
         did_tag[fill_idx]  <= req_device_id_i;
         pid_tag[fill_idx]  <= req_process_id_i;
         data_mem[fill_idx] <= fill_data;
      end
   end

   assign rsp_valid_o    = rsp_valid;
   assign rsp_hit_o      = rsp_hit;
   assign rsp_ens_o      = rsp_data.ens;
   assign rsp_sum_o      = rsp_data.sum;
   assign rsp_pscid_o    = rsp_data.pscid;
   assign rsp_fsc_mode_o = rsp_data.fsc_mode;
   assign rsp_fsc_ppn_o  = rsp_data.fsc_ppn;
   assign inval_done_o   = inval_done;
   assign hit_cnt_o      = hit_cnt;
   assign miss_cnt_o     = miss_cnt;
endmodule

// File: tb/tb_rv_iommu_pdtc_plru.sv
// Bench for rv_iommu_pdtc_plru: directed scenarios plus randomized traffic
// checked against a level/prefix-indexed PLRU cache model.
module tb_rv_iommu_pdtc_plru;
   localparam int ENTRIES = 8;
   localparam int LV      = 3;
   localparam int DID_W   = 24;
   localparam int PID_W   = 20;
   localparam int MAX_PPN = 34;
   localparam int CNT_W   = 2;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               req_valid = 1'b0, req_ready, req_fill = 1'b0;
   logic [DID_W-1:0]   req_did = '0;
   logic [PID_W-1:0]   req_pid = '0;
   logic               fill_ens = 1'b0, fill_sum = 1'b0;
   logic [19:0]        fill_pscid = '0;
   logic [3:0]         fill_mode = '0;
   logic [MAX_PPN-1:0] fill_ppn = '0;
   logic               rsp_valid, rsp_hit, rsp_ens, rsp_sum;
   logic [19:0]        rsp_pscid;
   logic [3:0]         rsp_mode;
   logic [MAX_PPN-1:0] rsp_ppn;
   logic               inval_valid = 1'b0, inval_ready, inval_done;
   logic [1:0]         inval_scope = '0;
   logic [DID_W-1:0]   inval_did = '0;
   logic [PID_W-1:0]   inval_pid = '0;
   logic [CNT_W-1:0]   hit_cnt, miss_cnt;

   always #5 clk = ~clk;

   rv_iommu_pdtc_plru #(
      .MAX_PPN(MAX_PPN), .ENTRIES(ENTRIES), .DID_W(DID_W), .PID_W(PID_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_fill_i(req_fill),
      .req_device_id_i(req_did), .req_process_id_i(req_pid),
      .fill_ens_i(fill_ens), .fill_sum_i(fill_sum), .fill_pscid_i(fill_pscid),
      .fill_fsc_mode_i(fill_mode), .fill_fsc_ppn_i(fill_ppn),
      .rsp_valid_o(rsp_valid), .rsp_hit_o(rsp_hit), .rsp_ens_o(rsp_ens), .rsp_sum_o(rsp_sum),
      .rsp_pscid_o(rsp_pscid), .rsp_fsc_mode_o(rsp_mode), .rsp_fsc_ppn_o(rsp_ppn),
      .inval_valid_i(inval_valid), .inval_ready_o(inval_ready), .inval_scope_i(inval_scope),
      .inval_device_id_i(inval_did), .inval_process_id_i(inval_pid), .inval_done_o(inval_done),
      .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: entries plus tree[level][prefix] PLRU bits.
   bit               m_valid [ENTRIES];
   logic [DID_W-1:0] m_did   [ENTRIES];
   logic [PID_W-1:0] m_pid   [ENTRIES];
   logic [59:0]      m_data  [ENTRIES];
   bit               tree    [LV][ENTRIES/2];
   int               m_hits, m_miss;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      for (int l = 0; l < LV; l++)
         for (int p = 0; p < ENTRIES / 2; p++) tree[l][p] = 1'b0;
      m_hits = 0;
      m_miss = 0;
   endfunction

   function automatic int m_find(input logic [DID_W-1:0] did, input logic [PID_W-1:0] pid);
      for (int i = 0; i < ENTRIES; i++)
         if (m_valid[i] && m_did[i] == did && m_pid[i] == pid) return i;
      return -1;
   endfunction

   function automatic int m_first_free();
      for (int i = 0; i < ENTRIES; i++)
         if (!m_valid[i]) return i;
      return -1;
   endfunction

   function automatic int m_victim();
      int p = 0;
      for (int l = 0; l < LV; l++) p = p * 2 + int'(tree[l][p]);
      return p;
   endfunction

   function automatic void m_touch(input int e);
      for (int l = 0; l < LV; l++)
         tree[l][e >> (LV - l)] = ((e >> (LV - 1 - l)) & 1) == 0;
   endfunction

   function automatic void m_inval(input logic [1:0] scope, input logic [DID_W-1:0] did,
                                   input logic [PID_W-1:0] pid);
      for (int i = 0; i < ENTRIES; i++) begin
         if (scope == 2'd1 && m_did[i] != did) continue;
         if (scope == 2'd2 && (m_did[i] != did || m_pid[i] != pid)) continue;
         m_valid[i] = 1'b0;
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input bit fill, input logic [DID_W-1:0] did, input logic [PID_W-1:0] pid,
                         input logic [59:0] d, output bit got_hit);
      int          idx, tgt;
      bit          exp_hit;
      logic [59:0] exp_d;
      req_valid = 1'b1;
      req_fill  = fill;
      req_did   = did;
      req_pid   = pid;
      {fill_ens, fill_sum, fill_pscid, fill_mode, fill_ppn} = d;
      #1;
      check("req_ready", 64'(req_ready), 64'd1);
      idx     = m_find(did, pid);
      exp_hit = !fill && idx >= 0;
      exp_d   = exp_hit ? m_data[idx] : 60'd0;
      step();
      got_hit = rsp_hit;
      check("rsp_valid", 64'(rsp_valid), 64'd1);
      check("rsp_hit", 64'(rsp_hit), 64'(exp_hit));
      check("rsp_data", 64'({rsp_ens, rsp_sum, rsp_pscid, rsp_mode, rsp_ppn}), 64'(exp_d));
      if (fill) begin
         tgt = idx >= 0 ? idx : m_first_free();
         if (tgt < 0) tgt = m_victim();
         m_valid[tgt] = 1'b1;
         m_did[tgt]   = did;
         m_pid[tgt]   = pid;
         m_data[tgt]  = d;
         m_touch(tgt);
      end else if (exp_hit) begin
         m_touch(idx);
         if (m_hits < CMAX) m_hits++;
      end else begin
         if (m_miss < CMAX) m_miss++;
      end
      check("hit_cnt", 64'(hit_cnt), 64'(m_hits));
      check("miss_cnt", 64'(miss_cnt), 64'(m_miss));
      req_valid = 1'b0;
   endtask

   task automatic do_inval(input logic [1:0] scope, input logic [DID_W-1:0] did,
                           input logic [PID_W-1:0] pid);
      inval_valid = 1'b1;
      inval_scope = scope;
      inval_did   = did;
      inval_pid   = pid;
      #1;
      check("inval_ready", 64'(inval_ready), 64'd1);
      check("req_ready_inval", 64'(req_ready), 64'd0);
      step();
      check("inval_done", 64'(inval_done), 64'd1);
      m_inval(scope, did, pid);
      inval_valid = 1'b0;
   endtask

   task automatic do_idle();
      step();
      check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
      check("idle_inval_done", 64'(inval_done), 64'd0);
   endtask

   task automatic do_reset();
      req_valid   = 1'b0;
      inval_valid = 1'b0;
      rst         = 1'b1;
      #1;
      check("rst_outputs", 64'({rsp_valid, rsp_hit, rsp_ens, rsp_sum, rsp_pscid, rsp_mode, inval_done}), 64'd0);
      check("rst_ppn", 64'(rsp_ppn), 64'd0);
      check("rst_counters", 64'({hit_cnt, miss_cnt}), 64'd0);
      check("rst_ready", 64'({req_ready, inval_ready}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      step();
   endtask

   function automatic logic [59:0] rand_data();
      return 60'({$urandom(), $urandom()});
   endfunction

   initial begin
      bit          h;
      int          seq [5];
      logic [59:0] d;
      seq = '{1, 2, 3, 3, 3};

      // Reset state, then the basic fill/lookup pair.
      do_reset();
      check("post_rst_ready", 64'({req_ready, inval_ready}), 64'b11);
      d = {1'b1, 1'b0, 20'h0ABCD, 4'd8, 34'h123};
      do_req(1'b1, 24'h000012, 20'h00034, d, h);
      do_req(1'b0, 24'h000012, 20'h00034, 60'd0, h);
      check("basic_pscid", 64'(rsp_pscid), 64'h0ABCD);
      check("basic_ppn", 64'(rsp_ppn), 64'h123);
      check("basic_hit_cnt", 64'(hit_cnt), 64'd1);
      do_idle();

      // PLRU replacement: after fills 0..7 and lookups 0,2,4,6 the victim is entry 1.
      do_reset();
      for (int i = 0; i < ENTRIES; i++) do_req(1'b1, 24'(i + 'h100), 20'(i), rand_data(), h);
      for (int i = 0; i < ENTRIES; i += 2) do_req(1'b0, 24'(i + 'h100), 20'(i), 60'd0, h);
      do_req(1'b1, 24'h200, 20'h99, rand_data(), h);
      do_req(1'b0, 24'h101, 20'd1, 60'd0, h);
      check("plru_victim_gone", 64'(h), 64'd0);
      do_req(1'b0, 24'h200, 20'h99, 60'd0, h);
      check("ninth_hits", 64'(h), 64'd1);
      d = {1'b0, 1'b1, 20'h55555, 4'd9, 34'h3ABC};
      do_req(1'b1, 24'h200, 20'h99, d, h);
      for (int i = 0; i < ENTRIES; i++)
         if (i != 1) begin
            do_req(1'b0, 24'(i + 'h100), 20'(i), 60'd0, h);
            check("no_tag_lost", 64'(h), 64'd1);
         end
      do_req(1'b0, 24'h200, 20'h99, 60'd0, h);
      check("overwrite_pscid", 64'(rsp_pscid), 64'h55555);

      // Scoped invalidation.
      do_reset();
      do_req(1'b1, 24'd5, 20'd1, rand_data(), h);
      do_req(1'b1, 24'd5, 20'd2, rand_data(), h);
      do_req(1'b1, 24'd6, 20'd1, rand_data(), h);
      do_inval(2'd1, 24'd5, 20'd0);
      do_req(1'b0, 24'd5, 20'd1, 60'd0, h);
      check("dev_inval_51", 64'(h), 64'd0);
      do_req(1'b0, 24'd5, 20'd2, 60'd0, h);
      check("dev_inval_52", 64'(h), 64'd0);
      do_req(1'b0, 24'd6, 20'd1, 60'd0, h);
      check("dev_inval_61", 64'(h), 64'd1);
      do_inval(2'd0, 24'd0, 20'd0);
      do_req(1'b0, 24'd6, 20'd1, 60'd0, h);
      check("all_inval_61", 64'(h), 64'd0);
      do_idle();

      // Invalidation and request together for three cycles.
      do_req(1'b1, 24'd7, 20'd3, rand_data(), h);
      do_req(1'b1, 24'd8, 20'd4, rand_data(), h);
      req_valid = 1'b1;
      req_fill  = 1'b0;
      req_did   = 24'd7;
      req_pid   = 20'd3;
      for (int c = 0; c < 3; c++) begin
         inval_valid = 1'b1;
         inval_scope = 2'd2;
         inval_did   = 24'd8;
         inval_pid   = 20'd4;
         #1;
         check("conflict_ready", 64'(req_ready), 64'd0);
         step();
         check("conflict_done", 64'(inval_done), 64'd1);
         check("conflict_no_rsp", 64'(rsp_valid), 64'd0);
         m_inval(2'd2, 24'd8, 20'd4);
      end
      inval_valid = 1'b0;
      do_req(1'b0, 24'd7, 20'd3, 60'd0, h);
      check("conflict_lookup_hit", 64'(h), 64'd1);
      do_req(1'b0, 24'd8, 20'd4, 60'd0, h);
      check("conflict_inval_miss", 64'(h), 64'd0);

      // Miss counter saturation.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         do_req(1'b0, 24'(i + 'h300), 20'd0, 60'd0, h);
         check("miss_sat", 64'(miss_cnt), 64'(seq[i]));
      end

      // Reset asserted right after a fill was accepted.
      do_req(1'b1, 24'h444, 20'h44, rand_data(), h);
      do_reset();
      do_req(1'b0, 24'h444, 20'h44, 60'd0, h);
      check("rst_fill_lost", 64'(h), 64'd0);

      // Randomized traffic over a small tag pool.
      for (int n = 0; n < 400; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 40)
            do_req(1'b1, 24'($urandom_range(0, 3)), 20'($urandom_range(0, 2)), rand_data(), h);
         else if (r < 85)
            do_req(1'b0, 24'($urandom_range(0, 3)), 20'($urandom_range(0, 2)), 60'd0, h);
         else if (r < 93)
            do_inval(2'($urandom_range(0, 3)), 24'($urandom_range(0, 3)), 20'($urandom_range(0, 2)));
         else if (r < 99)
            do_idle();
         else
            do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
